alu_dispatch: RTL and testbench
===============================

# alu_dispatch

Front-end issue stage for the `alu`. It accepts tagged operation requests over a valid/ready handshake and buffers them in a small in-order FIFO. It drives them one at a time onto the ALU's `valid`/`command`/`size`/`in_a`/`in_b` inputs, holding operands stable for the extra cycles the registered multiplier and count-ones paths need. It captures the ALU's registered `result`/`signal` and returns them with the request tag over a second valid/ready handshake.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `TAG_W`, 4: request tag width.
- `SLOW_WAIT`, 2: cycles operands are held before issue for commands 6 and 7; ≥1.

- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `req_valid` input 1: request offered.
- `req_ready` output 1: FIFO can accept.
- `req_cmd` input 3: ALU command, 0–7.
- `req_size` input 1: 0 = 16-bit, 1 = 32-bit.
- `req_a`, `req_b` input 32: operands.
- `req_tag` input TAG_W: returned unchanged with the result.
- `alu_valid` output 1: one-cycle capture strobe to the ALU.
- `alu_command` output 3, `alu_size` output 1, `alu_in_a`/`alu_in_b` output 32: operands of the op in flight.
- `alu_result` input 32, `alu_signal` input 2: ALU registered outputs.
- `rsp_valid` output 1, `rsp_ready` input 1: response handshake.
- `rsp_result` output 32, `rsp_signal` output 2, `rsp_tag` output TAG_W: response payload.
- `busy` output 1: FSM not in IDLE.
- `fifo_count` output $clog2(DEPTH)+1: occupied FIFO entries.

## Operation
- **FIFO**
  - Circular buffer with wrapping read/write pointers and an explicit count.
  - `req_ready` = (`fifo_count` < DEPTH). It is driven from the count only; there is no same-cycle bypass when full.
  - A push occurs on `req_valid && req_ready`.
  - A simultaneous push and pop leaves the count unchanged.
- **Operand register** holds {cmd, size, a, b, tag} of the op in flight. `alu_command`/`alu_size`/`alu_in_a`/`alu_in_b` are driven directly from it.
- **FSM states**
  - **IDLE**: if the FIFO is non-empty, pop the head into the operand register. Next state is SETUP if cmd ∈ {6,7}, else ISSUE.
  - **SETUP**: load the wait counter with SLOW_WAIT on entry and decrement each cycle. Go to ISSUE when the counter reaches 1. SETUP lasts exactly SLOW_WAIT cycles.
  - **ISSUE**: `alu_valid`=1 for exactly this cycle, then go to CAPTURE.
  - **CAPTURE**: latch `alu_result`, `alu_signal` and the operand tag into the response registers, then go to RSP.
  - **RSP**: `rsp_valid`=1. When `rsp_ready` is sampled high, go to IDLE.
- **In-order rules**: one op in flight at a time; responses are returned in acceptance order.
- **Payload pass-through**: no arithmetic or width manipulation.
  - Unsupported encodings, such as cmd 6 with size 1, are forwarded unchanged. The ALU's response (0/0) is returned as-is.
- **Hold rules**
  - The operand register is stable from the pop until the next pop.
  - The response registers are stable while `rsp_valid && !rsp_ready`.
- **Reset (asserted, asynchronous)**
  - State goes to IDLE; pointers, count, counter, operand and response registers clear to 0.
  - Queued and in-flight ops are discarded. No response is produced for them.

## Timing
- **Reset values**: `req_ready`=1, `alu_valid`=0, all `alu_*` = 0, `rsp_valid`=0, `rsp_result`=0, `rsp_signal`=0, `rsp_tag`=0, `busy`=0, `fifo_count`=0.
- **Fast op (cmd 0–5) into an empty, idle block**, accepted at edge T:
  - IDLE pop in cycle T+1.
  - `alu_valid` high in T+2.
  - CAPTURE in T+3.
  - `rsp_valid` high from T+4.
- **Slow op (cmd 6/7)**: `rsp_valid` is SLOW_WAIT cycles later than a fast op. Operands are stable for SLOW_WAIT+1 cycles, ending with the `alu_valid` cycle.
- **Throughput**: minimum 4 cycles per fast op with `rsp_ready` held high, since the FSM returns to IDLE after each response.
- **Capacity**: 1 op in flight plus DEPTH queued. `req_ready` stays low while full, until a pop.

## Test plan
- **Reset mid-operation**: queue 3 ops, assert `reset` low during SETUP of a cmd-6 op → all outputs at reset values immediately, `fifo_count`=0. After release no `rsp_valid` appears until a new request.
- **Single 32-bit ADD**: a=0x7FFFFFFF, b=0x1, tag=3, accepted at T → `alu_valid` only in T+2. `rsp_valid` at T+4 with result=0x80000000, signal=2'b10, tag=3.
- **16-bit MUL**: a=0x1234, b=0x0010, SLOW_WAIT=2 → `alu_in_*` stable 3 cycles, `alu_valid` 1 cycle. Response result=0x00012340, signal=2'b00.
- **Fill/backpressure**: `rsp_ready`=0, push tags 0..5 back-to-back → exactly 5 accepted (1 in flight + 4 queued), `req_ready` low. Payload is stable for 10 cycles with no `alu_valid`. Then with `rsp_ready`=1, responses arrive in tag order 0..4.
- **SATSUB 16-bit**: a=5, b=7 → result[15:0]=0x0000, signal=2'b10.
- **Unsupported encoding**: cmd 6 with size 1 → forwarded unchanged; result=0, signal=0 returned with the correct tag.

Source files
------------

// File: rtl/alu_dispatch.sv
// In-order issue stage for the alu: queues tagged requests, issues one at a time, returns tagged results.
// Fast op: response 4 cycles after accept (slow cmds 6/7 add SLOW_WAIT); req_ready falls when the FIFO is full.
module alu_dispatch #(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4,
  parameter int SLOW_WAIT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_cmd,
  input  logic                       req_size,
  input  logic [31:0]                req_a,
  input  logic [31:0]                req_b,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       alu_valid,
  output logic [2:0]                 alu_command,
  output logic                       alu_size,
  output logic [31:0]                alu_in_a,
  output logic [31:0]                alu_in_b,
  input  logic [31:0]                alu_result,
  input  logic [1:0]                 alu_signal,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_result,
  output logic [1:0]                 rsp_signal,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(SLOW_WAIT + 1);
  localparam int EW = 3 + 1 + 32 + 32 + TAG_W;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] ISSUE   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] RSP     = 3'd4;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;
  logic [2:0]       state;
  logic [WW-1:0]    wait_cnt;

  logic [2:0]       head_cmd;
  logic             head_size;
  logic [31:0]      head_a, head_b;
  logic [TAG_W-1:0] head_tag;

  logic [2:0]       op_cmd;
  logic             op_size;
  logic [31:0]      op_a, op_b;
  logic [TAG_W-1:0] op_tag;

  assign req_ready = (count < CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign {head_cmd, head_size, head_a, head_b, head_tag} = mem[rd_ptr];

  // Storage carries no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_cmd, req_size, req_a, req_b, req_tag};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      op_cmd     <= '0;
      op_size    <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_tag     <= '0;
      rsp_result <= '0;
      rsp_signal <= '0;
      rsp_tag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            op_cmd  <= head_cmd;
            op_size <= head_size;
            op_a    <= head_a;
            op_b    <= head_b;
            op_tag  <= head_tag;
            // Multiplier and count-ones paths are registered and need settled operands.
            if (head_cmd[2:1] == 2'b11) begin
              state    <= SETUP;
              wait_cnt <= WW'(SLOW_WAIT);
            end else begin
              state <= ISSUE;
            end
          end
        end
        SETUP: begin
          wait_cnt <= wait_cnt - WW'(1);
          if (wait_cnt == WW'(1)) state <= ISSUE;
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          rsp_result <= alu_result;
          rsp_signal <= alu_signal;
          rsp_tag    <= op_tag;
          state      <= RSP;
        end
        RSP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_valid   = (state == ISSUE);
  assign alu_command = op_cmd;
  assign alu_size    = op_size;
  assign alu_in_a    = op_a;
  assign alu_in_b    = op_b;
  assign rsp_valid   = (state == RSP);
  assign busy        = (state != IDLE);
  assign fifo_count  = count;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a small stand-in ALU whose outputs are only meaningful the cycle after alu_valid.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_size;
  logic [2:0]  req_cmd;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_tag;
  logic        alu_valid, alu_size;
  logic [2:0]  alu_command;
  logic [31:0] alu_in_a, alu_in_b, alu_result;
  logic [1:0]  alu_signal;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_signal;
  logic [3:0]  rsp_tag;
  logic        busy;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_dispatch #(.DEPTH(4), .TAG_W(4), .SLOW_WAIT(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_size(req_size),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_valid(alu_valid), .alu_command(alu_command), .alu_size(alu_size),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_result(alu_result), .alu_signal(alu_signal),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_signal(rsp_signal), .rsp_tag(rsp_tag),
    .busy(busy), .fifo_count(fifo_count)
  );

  // Stand-in ALU: 0 add, 3 saturating sub, 6 16-bit mul (32-bit unsupported), others xor.
  function automatic logic [33:0] alu_model(input logic [2:0] c, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    logic        ovf;
    case (c)
      3'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        ovf = (a[31] == b[31]) && (sum[31] != a[31]);
        if (s) return {sum[31:0], ovf, sum[32]};
        return {16'h0, sum[15:0], 2'b00};
      end
      3'd3: begin
        if (s) return (a < b) ? {32'h0, 2'b10} : {a - b, 2'b00};
        return (a[15:0] < b[15:0]) ? {32'h0, 2'b10} : {16'h0, a[15:0] - b[15:0], 2'b00};
      end
      3'd6: return s ? 34'h0 : {32'(a[15:0]) * 32'(b[15:0]), 2'b00};
      default: return {a ^ b, 2'b01};
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_valid) {alu_result, alu_signal} <= alu_model(alu_command, alu_size, alu_in_a, alu_in_b);
    else           {alu_result, alu_signal} <= {32'hDEADBEEF, 2'b11};
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] c, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] t);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = c; req_size = s; req_a = a; req_b = b; req_tag = t;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [31:0] snap_res, snap_a;
    bit          bad;
    int          idx, got;
    bit          acc;

    reset = 1'b0; req_valid = 1'b0; req_cmd = '0; req_size = 1'b0;
    req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b1;
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_alu_valid", alu_valid, 0);
    check("rst_alu_ops", {alu_command, alu_size, alu_in_a, alu_in_b}, 0);
    check("rst_rsp", {rsp_valid, rsp_result, rsp_signal, rsp_tag}, 0);
    check("rst_busy_count", {busy, fifo_count}, 0);
    @(negedge clk) reset = 1'b1;

    // 32-bit ADD, accepted at edge T
    drive_req(3'd0, 1'b1, 32'h7FFFFFFF, 32'h1, 4'd3);
    @(negedge clk);
    check("add_t1_idle", {busy, alu_valid, fifo_count}, {1'b0, 1'b0, 3'd1});
    @(negedge clk);
    check("add_t2_valid", alu_valid, 1);
    check("add_t2_ops", {alu_command, alu_size, alu_in_a, alu_in_b}, {3'd0, 1'b1, 32'h7FFFFFFF, 32'h1});
    @(negedge clk);
    check("add_t3", {alu_valid, rsp_valid}, 0);
    @(negedge clk);
    check("add_t4_rsp", {rsp_valid, rsp_result, rsp_signal, rsp_tag}, {1'b1, 32'h80000000, 2'b10, 4'd3});
    @(negedge clk);
    check("add_done", {rsp_valid, busy}, 0);

    // 16-bit MUL, slow path
    drive_req(3'd6, 1'b0, 32'h1234, 32'h0010, 4'd5);
    @(negedge clk);
    check("mul_t1", busy, 0);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check("mul_hold_ops", {alu_command, alu_size, alu_in_a, alu_in_b}, {3'd6, 1'b0, 32'h1234, 32'h0010});
      check("mul_valid", alu_valid, (i == 4));
    end
    @(negedge clk);
    check("mul_t5", {alu_valid, rsp_valid}, 0);
    @(negedge clk);
    check("mul_rsp", {rsp_valid, rsp_result, rsp_signal, rsp_tag}, {1'b1, 32'h00012340, 2'b00, 4'd5});

    // 16-bit SATSUB
    drive_req(3'd3, 1'b0, 32'd5, 32'd7, 4'd9);
    wait_rsp();
    check("satsub_rsp", {rsp_result[15:0], rsp_signal, rsp_tag}, {16'h0, 2'b10, 4'd9});

    // cmd 6 with size 1 passes through unchanged
    drive_req(3'd6, 1'b1, 32'hABCD, 32'h1234, 4'hC);
    wait_rsp();
    check("unsup_rsp", {rsp_result, rsp_signal, rsp_tag}, {32'h0, 2'b00, 4'hC});

    // Fill and backpressure
    @(negedge clk);
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_cmd = 3'd1; req_size = 1'b1;
      req_a = 32'h100 + 32'(idx); req_b = 32'h1000; req_tag = 4'(idx);
      acc = req_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    #1 req_valid = 1'b0;
    check("fill_accepted", idx, 5);
    @(negedge clk);
    check("fill_full", {req_ready, fifo_count}, {1'b0, 3'd4});
    check("fill_rsp0", {rsp_valid, rsp_tag}, {1'b1, 4'd0});
    snap_res = rsp_result; snap_a = alu_in_a;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (alu_valid || rsp_result != snap_res || alu_in_a != snap_a || !rsp_valid) bad = 1'b1;
    end
    check("fill_hold", bad, 0);
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (rsp_valid) begin
        check("fill_order_tag", rsp_tag, 4'(got));
        check("fill_result", {rsp_result, rsp_signal}, {32'h1100 + 32'(got), 2'b01});
        got++;
      end
      @(negedge clk);
    end
    check("fill_count", got, 5);

    // Reset during SETUP of a cmd-6 op with two more queued
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_cmd = (i == 0) ? 3'd6 : 3'd1; req_size = 1'b0;
      req_a = 32'h55; req_b = 32'h3; req_tag = 4'(8 + i);
      @(posedge clk);
    end
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("midrst_setup", {busy, alu_valid, fifo_count}, {1'b1, 1'b0, 3'd2});
    reset = 1'b0;
    #1;
    check("midrst_outputs", {req_ready, alu_valid, alu_command, alu_size, alu_in_a, alu_in_b}, {1'b1, 70'h0});
    check("midrst_rsp", {rsp_valid, rsp_result, rsp_signal, rsp_tag, busy, fifo_count}, 0);
    @(negedge clk) reset = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid || alu_valid || busy || fifo_count != 0) bad = 1'b1;
    end
    check("midrst_quiet", bad, 0);

    // New request after reset
    drive_req(3'd0, 1'b0, 32'd3, 32'd4, 4'd6);
    wait_rsp();
    check("post_rst_rsp", {rsp_result, rsp_signal, rsp_tag}, {32'd7, 2'b00, 4'd6});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
